sdram_rom_arbiter: RTL

//   N-channel SDRAM arbiter for ROM fetches, with an IOCTL download write path.

---
 rtl/sdram_rom_arbiter_if.sv | 44 ++++
 rtl/sdram_rom_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sdram_rom_arbiter_if.sv
// Bundle of channel, IOCTL-download and SDRAM-controller signals around sdram_rom_arbiter.
// master = arbiter view, slave = surrounding system (caches, loader, SDRAM controller).
interface sdram_rom_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DATA_W = 32
);
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_ack;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_err;
  logic [DATA_W-1:0]        ch_data;

  logic [24:0]              ioctl_addr;
  logic [7:0]               ioctl_data;
  logic [15:0]              ioctl_index;
  logic                     ioctl_wr;
  logic                     ioctl_download;
  logic                     dl_overrun;
  logic                     busy;

  logic [ADDR_W-1:0]        sdram_addr;
  logic [DATA_W-1:0]        sdram_data;
  logic                     sdram_we;
  logic                     sdram_req;
  logic                     sdram_ack;
  logic                     sdram_valid;
  logic [DATA_W-1:0]        sdram_q;

  modport master (
    input  ch_req, ch_addr, ioctl_addr, ioctl_data, ioctl_index, ioctl_wr, ioctl_download,
           sdram_ack, sdram_valid, sdram_q,
    output ch_ack, ch_valid, ch_err, ch_data, dl_overrun, busy, sdram_addr, sdram_data,
           sdram_we, sdram_req
  );

  modport slave (
    output ch_req, ch_addr, ioctl_addr, ioctl_data, ioctl_index, ioctl_wr, ioctl_download,
           sdram_ack, sdram_valid, sdram_q,
    input  ch_ack, ch_valid, ch_err, ch_data, dl_overrun, busy, sdram_addr, sdram_data,
           sdram_we, sdram_req
  );
endinterface

// File: rtl/sdram_rom_arbiter.sv
// N-channel SDRAM ROM-fetch arbiter with read timeout and IOCTL download write path.
// Define ROUND_ROBIN_EN for round-robin channel fairness; default is fixed lowest-index priority.
module sdram_rom_arbiter #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned ADDR_W   = 23,
  parameter int unsigned DATA_W   = 32,
  parameter logic [15:0] DL_INDEX = 16'h0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk_i,
  input  logic                reset_i,
  sdram_rom_arbiter_if.master bus_io
);
  localparam int unsigned Bytes  = DATA_W / 8;
  localparam int unsigned LaneW  = $clog2(Bytes);
  localparam int unsigned GrantW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {StIdle, StRdIssue, StRdWait, StDl} state_e;

  state_e            state_q;
  logic [GrantW-1:0] grant_q;
  logic [15:0]       timer_q;
  logic [NUM_CH-1:0] ch_ack_q, ch_valid_q, ch_err_q;
  logic [DATA_W-1:0] ch_data_q, sdram_data_q, pack_q;
  logic [ADDR_W-1:0] sdram_addr_q, dl_addr_q;
  logic              sdram_req_q, sdram_we_q, dirty_q, overrun_q;
`ifdef ROUND_ROBIN_EN
  logic [GrantW-1:0] rr_ptr_q;
`endif

  // Channel selection: first requester found from the search start.
  logic [GrantW-1:0] win_idx, idx;
  logic              win_found;
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
`ifdef ROUND_ROBIN_EN
      idx = GrantW'((int'(rr_ptr_q) + k) % NUM_CH);
`else
      idx = GrantW'(k);
`endif
      if (!win_found && bus_io.ch_req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Download byte packing; lane 0 lands in bits [7:0].
  logic [LaneW-1:0]  lane;
  logic [DATA_W-1:0] merged;
  logic [ADDR_W-1:0] word_addr;
  logic              wr_byte, top_lane, outstanding;
  always_comb begin
    lane   = bus_io.ioctl_addr[LaneW-1:0];
    merged = pack_q;
    merged[lane*8 +: 8] = bus_io.ioctl_data;
  end
  assign word_addr   = ADDR_W'(bus_io.ioctl_addr >> LaneW);
  assign wr_byte     = bus_io.ioctl_download & bus_io.ioctl_wr & (bus_io.ioctl_index == DL_INDEX);
  assign top_lane    = (lane == LaneW'(Bytes - 1));
  // A write issued earlier is still waiting unless acked this very cycle.
  assign outstanding = sdram_req_q & ~bus_io.sdram_ack;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      timer_q      <= '0;
      ch_ack_q     <= '0;
      ch_valid_q   <= '0;
      ch_err_q     <= '0;
      ch_data_q    <= '0;
      sdram_data_q <= '0;
      pack_q       <= '0;
      sdram_addr_q <= '0;
      dl_addr_q    <= '0;
      sdram_req_q  <= 1'b0;
      sdram_we_q   <= 1'b0;
      dirty_q      <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef ROUND_ROBIN_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      ch_ack_q   <= '0;
      ch_valid_q <= '0;
      ch_err_q   <= '0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.ioctl_download) begin
            state_q <= StDl;
          end else if (win_found) begin
            grant_q      <= win_idx;
            sdram_addr_q <= bus_io.ch_addr[win_idx*ADDR_W +: ADDR_W];
            sdram_we_q   <= 1'b0;
            sdram_req_q  <= 1'b1;
            state_q      <= StRdIssue;
          end
        end
        StRdIssue: begin
          if (bus_io.sdram_ack) begin
            sdram_req_q <= 1'b0;
            ch_ack_q    <= NUM_CH'(1) << grant_q;
            timer_q     <= '0;
            state_q     <= StRdWait;
`ifdef ROUND_ROBIN_EN
            rr_ptr_q    <= GrantW'((int'(grant_q) + 1) % NUM_CH);
`endif
          end
        end
        StRdWait: begin
          if (bus_io.sdram_valid) begin
            ch_data_q  <= bus_io.sdram_q;
            ch_valid_q <= NUM_CH'(1) << grant_q;
            state_q    <= StIdle;
          end else if (timer_q + 16'd1 == 16'(TIMEOUT)) begin
            ch_err_q <= NUM_CH'(1) << grant_q;
            state_q  <= StIdle;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        StDl: begin
          if (sdram_req_q && bus_io.sdram_ack) begin
            sdram_req_q <= 1'b0;
            sdram_we_q  <= 1'b0;
          end
          if (bus_io.ioctl_download) begin
            if (wr_byte) begin
              if (top_lane) begin
                pack_q  <= '0;
                dirty_q <= 1'b0;
                if (outstanding) begin
                  overrun_q <= 1'b1;
                end else begin
                  sdram_addr_q <= word_addr;
                  sdram_data_q <= merged;
                  sdram_we_q   <= 1'b1;
                  sdram_req_q  <= 1'b1;
                end
              end else begin
                pack_q    <= merged;
                dirty_q   <= 1'b1;
                dl_addr_q <= word_addr;
              end
            end
          end else if (!outstanding) begin
            // Flush a partial word (unwritten lanes are zero), then return to idle.
            if (dirty_q) begin
              sdram_addr_q <= dl_addr_q;
              sdram_data_q <= pack_q;
              sdram_we_q   <= 1'b1;
              sdram_req_q  <= 1'b1;
              pack_q       <= '0;
              dirty_q      <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.ch_ack     = ch_ack_q;
  assign bus_io.ch_valid   = ch_valid_q;
  assign bus_io.ch_err     = ch_err_q;
  assign bus_io.ch_data    = ch_data_q;
  assign bus_io.dl_overrun = overrun_q;
  assign bus_io.busy       = (state_q != StIdle);
  assign bus_io.sdram_addr = sdram_addr_q;
  assign bus_io.sdram_data = sdram_data_q;
  assign bus_io.sdram_we   = sdram_we_q;
  assign bus_io.sdram_req  = sdram_req_q;
endmodule
